// File: rtl/alu_exec_stage.sv
// Execute-stage wrapper: operand register feeding an external ALU, result register
// for writeback, architectural flag register and a saturating back-pressure counter.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_wen,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [2:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_rd,
    output logic             out_wen,
    output logic [2:0]       flags_q,
    output logic [CNTW-1:0]  stall_cnt
);

    logic             op_valid_reg;
    logic [4:0]       op_ctrl_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [RADDR-1:0] op_rd_reg;
    logic             op_wen_reg;

    logic             res_valid_reg;
    logic [WIDTH-1:0] res_result_reg;
    logic [RADDR-1:0] res_rd_reg;
    logic             res_wen_reg;

    logic [2:0]       flags_reg;
    logic [CNTW-1:0]  stall_reg;

    logic advance;
    logic accept;

    // advance moves the operand-register op into the result register; flush overrides it
    assign advance  = op_valid_reg & (~res_valid_reg | out_ready);
    assign in_ready = ~flush & (~op_valid_reg | advance);
    assign accept   = in_valid & in_ready;

    assign alu_input1  = op_a_reg;
    assign alu_input2  = op_b_reg;
    assign alu_control = op_ctrl_reg;

    assign out_valid  = res_valid_reg;
    assign out_result = res_result_reg;
    assign out_rd     = res_rd_reg;
    assign out_wen    = res_wen_reg;
    assign flags_q    = flags_reg;
    assign stall_cnt  = stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_reg   <= 1'b0;
            op_ctrl_reg    <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_rd_reg      <= '0;
            op_wen_reg     <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_result_reg <= '0;
            res_rd_reg     <= '0;
            res_wen_reg    <= 1'b0;
            flags_reg      <= 3'b000;
        end else if (flush) begin
            // data registers deliberately keep stale contents
            op_valid_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_valid_reg <= 1'b1;
                op_ctrl_reg  <= in_ctrl;
                op_a_reg     <= in_a;
                op_b_reg     <= in_b;
                op_rd_reg    <= in_rd;
                op_wen_reg   <= in_wen;
            end else if (advance) begin
                op_valid_reg <= 1'b0;
            end

            if (advance) begin
                res_valid_reg  <= 1'b1;
                res_result_reg <= alu_out;
                res_rd_reg     <= op_rd_reg;
                res_wen_reg    <= op_wen_reg;
                if (op_ctrl_reg[4]) begin
                    flags_reg <= alu_flags;
                end
            end else if (res_valid_reg && out_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (res_valid_reg && !out_ready && !(&stall_reg)) begin
            stall_reg <= stall_reg + CNTW'(1);
        end
    end

endmodule
